// File: rtl/l1_mem_port_arbiter.sv
// Two-requester arbiter for the single line-wide memory port (L1 DM cache and victim cache).
// One transaction at a time: IDLE -> BUSY -> GAP -> IDLE, round-robin with a same-line write-first override.
module l1_mem_port_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int LINE_BYTES     = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      r0_req_valid,
   input  logic                      r0_req_rw,
   input  logic [ADDR_WIDTH-1:0]     r0_req_addr,
   input  logic [LINE_BYTES*8-1:0]   r0_req_wdata,
   output logic                      r0_resp_valid,
   output logic [LINE_BYTES*8-1:0]   r0_resp_rdata,
   input  logic                      r1_req_valid,
   input  logic                      r1_req_rw,
   input  logic [ADDR_WIDTH-1:0]     r1_req_addr,
   input  logic [LINE_BYTES*8-1:0]   r1_req_wdata,
   output logic                      r1_resp_valid,
   output logic [LINE_BYTES*8-1:0]   r1_resp_rdata,
   output logic                      mem_req_valid,
   output logic                      mem_req_rw,
   output logic [ADDR_WIDTH-1:0]     mem_req_addr,
   output logic [LINE_BYTES*8-1:0]   mem_req_wdata,
   input  logic                      mem_resp_valid,
   input  logic [LINE_BYTES*8-1:0]   mem_resp_rdata,
   output logic                      busy,
   output logic                      grant_id,
   output logic                      timeout_err
);

   localparam int LINE_W      = LINE_BYTES * 8;
   localparam int OFFSET_BITS = $clog2(LINE_BYTES);

   localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
   localparam bit          TIMEOUT_EN    = (TIMEOUT_CYCLES != 0);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   logic [1:0]            state_q, state_d;
   logic                  last_grant_q, last_grant_d;
   logic                  grant_id_q, grant_id_d;
   logic                  timeout_err_q, timeout_err_d;
   logic [15:0]           count_q, count_d;
   logic                  rw_q, rw_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LINE_W-1:0]     wdata_q, wdata_d;

   logic                  same_line;
   logic                  winner;
   logic                  in_busy;
   logic                  resp_fire;

   // Winner selection: lone requester, then same-line write-first, then round-robin.
   always_comb begin
      same_line = (r0_req_addr[ADDR_WIDTH-1:OFFSET_BITS] == r1_req_addr[ADDR_WIDTH-1:OFFSET_BITS]);
      if (r0_req_valid && !r1_req_valid) begin
         winner = 1'b0;
      end else if (!r0_req_valid && r1_req_valid) begin
         winner = 1'b1;
      end else if (same_line && (r0_req_rw != r1_req_rw)) begin
         winner = r1_req_rw;
      end else begin
         winner = ~last_grant_q;
      end
   end

   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      grant_id_d    = grant_id_q;
      timeout_err_d = timeout_err_q;
      count_d       = count_q;
      rw_d          = rw_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (r0_req_valid || r1_req_valid) begin
               grant_id_d = winner;
               rw_d       = winner ? r1_req_rw    : r0_req_rw;
               addr_d     = winner ? r1_req_addr  : r0_req_addr;
               wdata_d    = winner ? r1_req_wdata : r0_req_wdata;
               count_d    = '0;
               state_d    = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (mem_resp_valid) begin
               last_grant_d = grant_id_q;
               state_d      = ST_GAP;
            end else begin
               // Saturating wait counter; a timeout only flags, the transaction keeps waiting.
               if (count_q != 16'hFFFF) begin
                  count_d = count_q + 16'd1;
               end
               if (TIMEOUT_EN && (count_d >= TIMEOUT_LIMIT)) begin
                  timeout_err_d = 1'b1;
               end
            end
         end
         ST_GAP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         last_grant_q  <= 1'b1;
         grant_id_q    <= 1'b0;
         timeout_err_q <= 1'b0;
         count_q       <= '0;
         rw_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         grant_id_q    <= grant_id_d;
         timeout_err_q <= timeout_err_d;
         count_q       <= count_d;
         rw_q          <= rw_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
      end
   end

   // Memory responses are only meaningful while a transaction is outstanding.
   always_comb begin
      in_busy       = (state_q == ST_BUSY);
      resp_fire     = in_busy && mem_resp_valid;
      busy          = in_busy;
      grant_id      = grant_id_q;
      timeout_err   = timeout_err_q;
      mem_req_valid = in_busy;
      mem_req_rw    = in_busy ? rw_q    : 1'b0;
      mem_req_addr  = in_busy ? addr_q  : '0;
      mem_req_wdata = in_busy ? wdata_q : '0;
      r0_resp_valid = resp_fire && !grant_id_q;
      r1_resp_valid = resp_fire &&  grant_id_q;
      r0_resp_rdata = r0_resp_valid ? mem_resp_rdata : '0;
      r1_resp_rdata = r1_resp_valid ? mem_resp_rdata : '0;
   end

endmodule
